// File: rtl/stream_pkg.sv
// Shared definitions for the word-to-lane streamer: FSM state type and
// small sizing helpers used by the top level and the lane shifter.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // Number of output beats per memory word.
    function automatic int unsigned lanes_f(input int unsigned word_w, input int unsigned lane_w);
        return word_w / lane_w;
    endfunction

    // Counter width able to index n items, never narrower than one bit.
    function automatic int unsigned ctr_w_f(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_lane_shifter.sv
// Word-to-lane shifter: parallel-loads one word, presents it one lane at a
// time in the configured order, and flags the final lane of the word.
module word_lane_shifter
    import stream_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned LANE_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_advance,
    output logic [LANE_W-1:0] o_beat,
    output logic              o_last_beat
);

    localparam int unsigned LANES  = lanes_f(WORD_W, LANE_W);
    localparam int unsigned BEAT_W = ctr_w_f(LANES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

    logic [WORD_W-1:0] r_sr;
    logic [BEAT_W-1:0] r_beat;

    // Load wins over advance so a new word can enter on the final beat of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_beat <= '0;
        end else if (i_load) begin
            r_sr   <= i_word;
            r_beat <= '0;
        end else if (i_advance) begin
            if (LSB_FIRST) begin
                r_sr <= r_sr >> LANE_W;
            end else begin
                r_sr <= r_sr << LANE_W;
            end
            if (!o_last_beat) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    generate
        if (LSB_FIRST) begin : g_lsb
            assign o_beat = r_sr[LANE_W-1:0];
        end else begin : g_msb
            assign o_beat = r_sr[WORD_W-1 -: LANE_W];
        end
    endgenerate

    assign o_last_beat = (r_beat == LAST_BEAT);

endmodule

// File: rtl/mem_word_streamer.sv
// Memory word streamer: reads a run of consecutive RAM words (1-cycle read
// latency) and emits each as WORD_W/LANE_W beats on a valid/ready port.
// Optional gapless prefetch: define STREAM_PREFETCH_EN.
module mem_word_streamer
    import stream_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              flush,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] ONE_WORD = CNT_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_words;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_done;

    logic              w_xfer;
    logic              w_last_beat;
    logic              w_word_end;
    logic              w_load;
    logic [WORD_W-1:0] w_load_word;

    assign out_valid  = (r_state == ST_SEND);
    assign busy       = (r_state != ST_IDLE);
    assign w_xfer     = out_valid & out_ready;
    assign w_word_end = w_xfer & w_last_beat;
    assign out_last   = out_valid & w_last_beat & (r_words == ONE_WORD);
    assign mem_re     = r_mem_re;
    assign mem_addr   = r_mem_addr;
    assign done       = r_done;

`ifdef STREAM_PREFETCH_EN
    localparam logic [CNT_W-1:0] TWO_WORDS = CNT_W'(2);

    logic [WORD_W-1:0] r_buf;
    logic              r_buf_valid;
    logic              r_pf_pending;

    // Next word comes from the buffer if it already landed, else straight off the RAM bus.
    assign w_load      = (r_state == ST_LOAD) |
                         (w_word_end & (r_words != ONE_WORD) & (r_buf_valid | r_pf_pending));
    assign w_load_word = ((r_state == ST_SEND) && r_buf_valid) ? r_buf : mem_rdata;
`else
    assign w_load      = (r_state == ST_LOAD);
    assign w_load_word = mem_rdata;
`endif

    word_lane_shifter #(
        .WORD_W   (WORD_W),
        .LANE_W   (LANE_W),
        .LSB_FIRST(LSB_FIRST)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_word     (w_load_word),
        .i_advance  (w_xfer),
        .o_beat     (out_data),
        .o_last_beat(w_last_beat)
    );

    // Run control FSM with registered read strobe, read address and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_words    <= '0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_done     <= 1'b0;
`ifdef STREAM_PREFETCH_EN
            r_buf        <= '0;
            r_buf_valid  <= 1'b0;
            r_pf_pending <= 1'b0;
`endif
        end else if (flush) begin
            r_state  <= ST_IDLE;
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;
`ifdef STREAM_PREFETCH_EN
            r_buf_valid  <= 1'b0;
            r_pf_pending <= 1'b0;
`endif
        end else begin
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;
`ifdef STREAM_PREFETCH_EN
            // A prefetch read issued in SEND returns data one cycle later; park it
            // unless that same cycle's final beat consumes it directly.
            r_pf_pending <= r_mem_re & (r_state == ST_SEND);
            if (r_pf_pending && (r_state == ST_SEND) && !w_word_end) begin
                r_buf       <= mem_rdata;
                r_buf_valid <= 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            r_addr     <= base_addr;
                            r_words    <= word_count;
                            r_mem_addr <= base_addr;
                            r_mem_re   <= 1'b1;
                            r_state    <= ST_READ;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= ST_SEND;
`ifdef STREAM_PREFETCH_EN
                    if (r_words > ONE_WORD) begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= r_addr + ADDR_W'(1);
                    end
`endif
                end
                ST_SEND: begin
                    if (w_word_end) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_words <= r_words - ONE_WORD;
                        if (r_words == ONE_WORD) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
`ifdef STREAM_PREFETCH_EN
                            if (r_buf_valid || r_pf_pending) begin
                                r_buf_valid <= 1'b0;
                                if (r_words > TWO_WORDS) begin
                                    r_mem_re   <= 1'b1;
                                    r_mem_addr <= r_addr + ADDR_W'(2);
                                end
                            end else if (r_mem_re) begin
                                // Single-beat words: the prefetch is still on the bus.
                                r_state <= ST_LOAD;
                            end else begin
                                r_state    <= ST_READ;
                                r_mem_re   <= 1'b1;
                                r_mem_addr <= r_addr + ADDR_W'(1);
                            end
`else
                            r_state    <= ST_READ;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_addr + ADDR_W'(1);
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_streamer.sv
// Testbench for mem_word_streamer: two instances (32->8 LSB-first and
// 32->16 MSB-first) share one RAM image and one stimulus stream; beats,
// addresses, out_last, done and handshake stability are checked against
// a queue-based model built from the RAM contents.
module tb_mem_word_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  word_count;
    logic        flush;
    logic        out_ready;

    logic        a_mem_re, b_mem_re;
    logic [4:0]  a_mem_addr, b_mem_addr;
    logic [31:0] a_mem_rdata, b_mem_rdata;
    logic [7:0]  a_out_data;
    logic [15:0] b_out_data;
    logic        a_out_valid, b_out_valid, a_out_last, b_out_last;
    logic        a_busy, b_busy, a_done, b_done;

    logic [31:0] ram [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_mem_re) a_mem_rdata <= ram[a_mem_addr];
        if (b_mem_re) b_mem_rdata <= ram[b_mem_addr];
    end

    mem_word_streamer #(.WORD_W(32), .LANE_W(8), .ADDR_W(5), .LSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .flush(flush), .mem_re(a_mem_re), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    mem_word_streamer #(.WORD_W(32), .LANE_W(16), .ADDR_W(5), .LSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .flush(flush), .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

`ifdef STREAM_PREFETCH_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 2;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  exp_a[$], got_a[$];
    logic [15:0] exp_b[$], got_b[$];
    logic [4:0]  exp_addr[$], addr_a[$], addr_b[$];
    int          cyc_a[$], cyc_b[$];
    int          last_a, last_b, done_a, done_b, done_k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_case(input string name, input logic [4:0] base, input logic [5:0] cnt,
                            input bit rnd_ready, input int stall_beat, input int flush_beat,
                            input bit busy_start, input bit chk_lat, input bit chk_gap);
        logic [31:0] word;
        logic [4:0]  a;
        int          k, end_k, stall_left, flush_k, first_re_k, first_v_k;
        bit          flushed, stalled, pa_v, pa_r, pb_v, pb_r, pflush;
        logic [7:0]  pa_d;
        logic [15:0] pb_d;

        exp_a.delete(); exp_b.delete(); exp_addr.delete();
        got_a.delete(); got_b.delete(); addr_a.delete(); addr_b.delete();
        cyc_a.delete(); cyc_b.delete();
        last_a = 0; last_b = 0; done_a = 0; done_b = 0; done_k = -1;

        for (int w = 0; w < int'(cnt); w++) begin
            a = base + 5'(w);
            exp_addr.push_back(a);
            word = ram[a];
            for (int b = 0; b < 4; b++) exp_a.push_back(8'((word >> (8 * b)) & 32'hFF));
            for (int b = 0; b < 2; b++) exp_b.push_back(16'((word >> (16 * (1 - b))) & 32'hFFFF));
        end

        @(negedge clk);
        base_addr = base; word_count = cnt; start = 1'b1; out_ready = 1'b1;
        k = 0; end_k = -1; stall_left = 0; flush_k = -1; first_re_k = -1; first_v_k = -1;
        flushed = 0; stalled = 0; pa_v = 0; pa_r = 0; pb_v = 0; pb_r = 0; pflush = 0;
        pa_d = '0; pb_d = '0;

        while (1) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            flush = 1'b0;
            if (k == 1) begin
                base_addr = 5'($urandom); word_count = 6'($urandom);
            end
            if (busy_start && k == 5) begin
                start = 1'b1; base_addr = 5'($urandom); word_count = 6'($urandom_range(1, 32));
            end
            if (flushed && k == flush_k + 1) begin
                check({name, " flush busy a"}, a_busy, 0);
                check({name, " flush valid a"}, a_out_valid, 0);
                check({name, " flush mem_re a"}, a_mem_re, 0);
                check({name, " flush busy b"}, b_busy, 0);
                check({name, " flush valid b"}, b_out_valid, 0);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else if (!stalled && stall_beat >= 0 && got_a.size() == stall_beat && a_out_valid) begin
                stalled = 1; out_ready = 1'b0; stall_left = 4;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!flushed && flush_beat >= 0 && got_a.size() == flush_beat && a_out_valid) begin
                flush = 1'b1; out_ready = 1'b0; flushed = 1; flush_k = k;
            end
            if (pa_v && !pa_r && !pflush) begin
                check({name, " hold valid a"}, a_out_valid, 1);
                check({name, " hold data a"}, a_out_data, pa_d);
            end
            if (pb_v && !pb_r && !pflush) begin
                check({name, " hold valid b"}, b_out_valid, 1);
                check({name, " hold data b"}, b_out_data, pb_d);
            end
            if (a_mem_re && first_re_k < 0) first_re_k = k;
            if (a_out_valid && first_v_k < 0) first_v_k = k;
            if (a_mem_re) addr_a.push_back(a_mem_addr);
            if (b_mem_re) addr_b.push_back(b_mem_addr);
            if (a_out_valid && out_ready) begin
                check({name, " last a"}, a_out_last, got_a.size() == exp_a.size() - 1);
                if (a_out_last) last_a++;
                got_a.push_back(a_out_data); cyc_a.push_back(k);
            end
            if (b_out_valid && out_ready) begin
                check({name, " last b"}, b_out_last, got_b.size() == exp_b.size() - 1);
                if (b_out_last) last_b++;
                got_b.push_back(b_out_data); cyc_b.push_back(k);
            end
            if (a_done) begin
                done_a++;
                if (done_k < 0) done_k = k;
            end
            if (b_done) done_b++;
            pa_v = a_out_valid; pa_r = out_ready; pa_d = a_out_data;
            pb_v = b_out_valid; pb_r = out_ready; pb_d = b_out_data;
            pflush = flush;
            if (end_k < 0 && (flushed ? (k >= flush_k + 1) : (done_a > 0 && done_b > 0))) end_k = k + 6;
            if (k == end_k || k >= 3000) break;
        end
        start = 1'b0; flush = 1'b0; out_ready = 1'b1;

        check({name, " completed in budget"}, k == end_k, 1);
        if (chk_lat) begin
            check({name, " mem_re latency"}, first_re_k, 1);
            check({name, " out_valid latency"}, first_v_k, 3);
        end
        if (flushed) begin
            check({name, " no done a"}, done_a, 0);
            check({name, " no done b"}, done_b, 0);
            check({name, " beats before flush"}, got_a.size(), flush_beat);
        end else begin
            check({name, " beat count a"}, got_a.size(), exp_a.size());
            check({name, " beat count b"}, got_b.size(), exp_b.size());
            for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
                check($sformatf("%s beat a[%0d]", name, i), got_a[i], exp_a[i]);
            for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
                check($sformatf("%s beat b[%0d]", name, i), got_b[i], exp_b[i]);
            check({name, " read count a"}, addr_a.size(), exp_addr.size());
            check({name, " read count b"}, addr_b.size(), exp_addr.size());
            for (int i = 0; i < exp_addr.size() && i < addr_a.size(); i++)
                check($sformatf("%s addr a[%0d]", name, i), addr_a[i], exp_addr[i]);
            for (int i = 0; i < exp_addr.size() && i < addr_b.size(); i++)
                check($sformatf("%s addr b[%0d]", name, i), addr_b[i], exp_addr[i]);
            check({name, " done pulses a"}, done_a, 1);
            check({name, " done pulses b"}, done_b, 1);
            check({name, " last count a"}, last_a, (cnt != 0) ? 1 : 0);
            check({name, " last count b"}, last_b, (cnt != 0) ? 1 : 0);
            if (cnt == 0) check({name, " empty-run done at T+1"}, done_k, 1);
        end
        if (chk_gap && cyc_a.size() == 4 * int'(cnt) && cyc_b.size() == 2 * int'(cnt)) begin
            for (int w = 0; w + 1 < int'(cnt); w++) begin
                check($sformatf("%s gap a w%0d", name, w), cyc_a[4 * (w + 1)] - cyc_a[4 * w + 3] - 1, EXP_GAP);
                check($sformatf("%s gap b w%0d", name, w), cyc_b[2 * (w + 1)] - cyc_b[2 * w + 1] - 1, EXP_GAP);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        for (int i = 0; i < 32; i++) ram[i] = $urandom;
        ram[3] = 32'hA1B2C3D4;
        ram[4] = 32'h11223344;
        repeat (3) @(negedge clk);
        check("reset busy", {a_busy, b_busy}, 0);
        check("reset valid", {a_out_valid, b_out_valid}, 0);
        check("reset mem_re", {a_mem_re, b_mem_re}, 0);
        check("reset done/last", {a_done, b_done, a_out_last, b_out_last}, 0);
        check("reset mem_addr", {a_mem_addr, b_mem_addr}, 0);
        check("reset out_data", {a_out_data, b_out_data}, 0);
        rst = 1'b0;

        run_case("basic", 5'd3, 6'd2, 0, -1, -1, 0, 1, 0);
        check("basic first beat", got_a[0], 8'hD4);
        check("basic final beat", got_a[7], 8'h11);
        check("basic msb-first b", got_b[0], 16'hA1B2);

        run_case("stall", 5'd3, 6'd2, 0, 2, -1, 0, 1, 0);
        check("stall beat2", got_a[2], 8'hB2);

        run_case("wrap", 5'd31, 6'd3, 0, -1, -1, 0, 0, 0);
        check("wrap addr0", addr_a[0], 5'd31);
        check("wrap addr1", addr_a[1], 5'd0);
        check("wrap addr2", addr_a[2], 5'd1);

        run_case("flush", 5'd3, 6'd2, 0, -1, 1, 0, 0, 0);
        run_case("after flush", 5'd3, 6'd2, 0, -1, -1, 0, 1, 0);
        run_case("empty", 5'd9, 6'd0, 0, -1, -1, 0, 0, 0);
        check("empty no read", addr_a.size(), 0);
        run_case("start while busy", 5'd10, 6'd3, 0, -1, -1, 1, 0, 0);
        run_case("gap", 5'd8, 6'd4, 0, -1, -1, 0, 1, 1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) ram[i] = $urandom;
            run_case($sformatf("random%0d", r), 5'($urandom), 6'($urandom_range(1, 8)), 1, -1, -1, 0, 0, 0);
        end
        run_case("full memory", 5'($urandom), 6'd32, 1, -1, -1, 0, 0, 0);

        // Reset in the middle of a run aborts it without a done pulse.
        @(negedge clk);
        base_addr = 5'd3; word_count = 6'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-run reset busy", {a_busy, b_busy}, 0);
        check("mid-run reset valid", {a_out_valid, b_out_valid}, 0);
        done_a = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_done || b_done) done_a++;
        end
        check("mid-run reset no done", done_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
